// File: rtl/cgra_config_loader.sv
// PE configuration-load transmitter: accepts host context entries over a
// valid/ready stream and writes them into the PE array's config memories.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   load_start            begin a load session (honoured in IDLE and RUN)
//   in_valid / in_ready   host entry handshake
//   in_pe_id ... in_last  host entry fields
//   config_*              broadcast config fields, qualified by the strobe
//   write_config_data     per-PE write strobe (one-hot, or all-ones)
//   config_reset          one-cycle context reset pulse after the last entry
//   running               array configured and executing
//   err_bad_entry         sticky: illegal PE id or context index seen
//   entries_written       legal entries written this session (saturating)
module cgra_config_loader #(
    parameter int PE_NUM                     = 16,
    parameter int PE_ID_WIDTH                = 5,
    parameter int NEIGHBOR_PE_NUM_BIT_LENGTH = 3,
    parameter int OPERATION_BIT_LENGTH       = 4,
    parameter int DATA_WIDTH                 = 32,
    parameter int CONTEXT_SIZE_BIT_LENGTH    = 3,
    parameter int CONTEXT_HW_SIZE            = 8,
    parameter int COUNT_WIDTH                = 16
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  load_start,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [PE_ID_WIDTH-1:0]                in_pe_id,
    input  logic                                  in_broadcast,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    in_context_index,
    input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] in_input_PE_1,
    input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] in_input_PE_2,
    input  logic [OPERATION_BIT_LENGTH-1:0]       in_op,
    input  logic [DATA_WIDTH-1:0]                 in_const_data,
    input  logic                                  in_last,
    output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_1,
    output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_2,
    output logic [OPERATION_BIT_LENGTH-1:0]       config_op,
    output logic [DATA_WIDTH-1:0]                 config_const_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    config_index,
    output logic [PE_NUM-1:0]                     write_config_data,
    output logic                                  config_reset,
    output logic                                  running,
    output logic                                  err_bad_entry,
    output logic [COUNT_WIDTH-1:0]                entries_written
);

    // RST_WR carries the final strobe, RST_PULSE carries config_reset,
    // so the two never overlap.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RST_WR,
        RST_PULSE,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic              accept;
    logic              start;
    logic              legal_pe;
    logic              legal_ctx;
    logic              legal;
    logic [PE_NUM-1:0] strobe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        config_reset = 1'b0;
        running      = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_start) state_next = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_next = RST_WR;
            end
            RST_WR: begin
                state_next = RST_PULSE;
            end
            RST_PULSE: begin
                config_reset = 1'b1;
                state_next   = RUN;
            end
            RUN: begin
                running = 1'b1;
                if (load_start) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && (state == LOAD);
    assign start  = load_start && ((state == IDLE) || (state == RUN));

    // Widen before comparing so the checks stay meaningful for any
    // parameterisation, including ones where the field cannot overflow.
    always_comb begin
        legal_pe  = in_broadcast || (32'(in_pe_id) < PE_NUM);
        legal_ctx = 32'(in_context_index) < CONTEXT_HW_SIZE;
        legal     = legal_pe && legal_ctx;
        strobe    = '0;
        for (int i = 0; i < PE_NUM; i++) begin
            strobe[i] = legal && (in_broadcast || (32'(in_pe_id) == i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            config_input_PE_1 <= '0;
            config_input_PE_2 <= '0;
            config_op         <= '0;
            config_const_data <= '0;
            config_index      <= '0;
            write_config_data <= '0;
            err_bad_entry     <= 1'b0;
            entries_written   <= '0;
        end else begin
            write_config_data <= accept ? strobe : '0;
            if (accept) begin
                config_input_PE_1 <= in_input_PE_1;
                config_input_PE_2 <= in_input_PE_2;
                config_op         <= in_op;
                config_const_data <= in_const_data;
                config_index      <= in_context_index;
            end
            if (start) begin
                err_bad_entry   <= 1'b0;
                entries_written <= '0;
            end else if (accept) begin
                if (!legal) begin
                    err_bad_entry <= 1'b1;
                end else if (entries_written != '1) begin
                    entries_written <= entries_written + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cgra_config_loader.sv
// Testbench for cgra_config_loader: directed and randomized load sessions
// checked cycle by cycle against a transaction-level reference model.
module tb_cgra_config_loader;

    logic        clk;
    logic        reset_n;
    logic        load_start;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_pe_id;
    logic        in_broadcast;
    logic [2:0]  in_context_index;
    logic [2:0]  in_input_PE_1;
    logic [2:0]  in_input_PE_2;
    logic [3:0]  in_op;
    logic [31:0] in_const_data;
    logic        in_last;
    logic [2:0]  config_input_PE_1;
    logic [2:0]  config_input_PE_2;
    logic [3:0]  config_op;
    logic [31:0] config_const_data;
    logic [2:0]  config_index;
    logic [15:0] write_config_data;
    logic        config_reset;
    logic        running;
    logic        err_bad_entry;
    logic [15:0] entries_written;

    typedef struct packed {
        logic [4:0]  pe;
        logic        bc;
        logic [2:0]  ctx;
        logic [2:0]  p1;
        logic [2:0]  p2;
        logic [3:0]  op;
        logic [31:0] cd;
    } ent_t;

    int   total;
    int   bad;
    int   m_cnt;
    bit   m_err;
    ent_t sess[$];
    ent_t last_e;

    cgra_config_loader dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .load_start        (load_start),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_pe_id          (in_pe_id),
        .in_broadcast      (in_broadcast),
        .in_context_index  (in_context_index),
        .in_input_PE_1     (in_input_PE_1),
        .in_input_PE_2     (in_input_PE_2),
        .in_op             (in_op),
        .in_const_data     (in_const_data),
        .in_last           (in_last),
        .config_input_PE_1 (config_input_PE_1),
        .config_input_PE_2 (config_input_PE_2),
        .config_op         (config_op),
        .config_const_data (config_const_data),
        .config_index      (config_index),
        .write_config_data (write_config_data),
        .config_reset      (config_reset),
        .running           (running),
        .err_bad_entry     (err_bad_entry),
        .entries_written   (entries_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ent_t mk(input int pe, input bit bc, input int ctx,
                                input int op, input int cd);
        ent_t e;
        e.pe  = 5'(pe);
        e.bc  = bc;
        e.ctx = 3'(ctx);
        e.p1  = 3'($urandom);
        e.p2  = 3'($urandom);
        e.op  = 4'(op);
        e.cd  = 32'(cd);
        return e;
    endfunction

    function automatic ent_t rnd(input bit allow_bad);
        ent_t e;
        e = mk(allow_bad ? $urandom_range(0, 31) : $urandom_range(0, 15),
               $urandom_range(0, 5) == 0, $urandom_range(0, 7),
               $urandom_range(0, 15), $urandom);
        return e;
    endfunction

    function automatic bit is_legal(input ent_t e);
        return e.bc || (int'(e.pe) < 16);
    endfunction

    function automatic logic [15:0] exp_strobe(input ent_t e);
        logic [15:0] s;
        s = '0;
        if (e.bc) s = '1;
        else if (int'(e.pe) < 16) s[e.pe[3:0]] = 1'b1;
        return s;
    endfunction

    task automatic drive(input ent_t e, input bit v, input bit l);
        in_valid         = v;
        in_last          = l;
        in_pe_id         = e.pe;
        in_broadcast     = e.bc;
        in_context_index = e.ctx;
        in_input_PE_1    = e.p1;
        in_input_PE_2    = e.p2;
        in_op            = e.op;
        in_const_data    = e.cd;
    endtask

    task automatic chk_fields(input string tag, input ent_t e);
        chk({tag, "_p1"}, 64'(config_input_PE_1), 64'(e.p1));
        chk({tag, "_p2"}, 64'(config_input_PE_2), 64'(e.p2));
        chk({tag, "_op"}, 64'(config_op), 64'(e.op));
        chk({tag, "_cd"}, 64'(config_const_data), 64'(e.cd));
        chk({tag, "_ctx"}, 64'(config_index), 64'(e.ctx));
    endtask

    // gap < 0 picks a random gap of 0..1 idle cycles per entry.
    task automatic run_session(input int gap, input bit poke, input bit from_run);
        int n;
        int g;
        n = sess.size();
        chk("running_pre", 64'(running), 64'(from_run));
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
        chk("ready_load", 64'(in_ready), 64'd1);
        chk("running_load", 64'(running), 64'd0);
        chk("err_clear", 64'(err_bad_entry), 64'd0);
        chk("cnt_clear", 64'(entries_written), 64'd0);
        chk("strobe_start", 64'(write_config_data), 64'd0);
        for (int k = 0; k < n; k++) begin
            g = (gap < 0) ? $urandom_range(0, 1) : gap;
            for (int j = 0; j < g; j++) begin
                drive(rnd(1'b1), 1'b0, $urandom_range(0, 1) == 1);
                load_start = poke && (j == 0);
                tick();
                load_start = 1'b0;
                chk("gap_strobe", 64'(write_config_data), 64'd0);
                chk("gap_ready", 64'(in_ready), 64'd1);
                chk("gap_cnt", 64'(entries_written), 64'(m_cnt));
                chk("gap_cfgrst", 64'(config_reset), 64'd0);
                if (k > 0) chk_fields("hold", last_e);
            end
            drive(sess[k], 1'b1, k == n - 1);
            tick();
            if (is_legal(sess[k])) m_cnt++;
            else m_err = 1'b1;
            last_e = sess[k];
            chk("strobe", 64'(write_config_data), 64'(exp_strobe(sess[k])));
            chk_fields("wr", sess[k]);
            chk("cnt", 64'(entries_written), 64'(m_cnt));
            chk("err", 64'(err_bad_entry), 64'(m_err));
            chk("cfgrst_wr", 64'(config_reset), 64'd0);
            chk("ready_wr", 64'(in_ready), (k == n - 1) ? 64'd0 : 64'd1);
        end
        drive(rnd(1'b1), 1'b0, 1'b0);
        tick();
        chk("cfgrst_pulse", 64'(config_reset), 64'd1);
        chk("strobe_pulse", 64'(write_config_data), 64'd0);
        chk("running_pulse", 64'(running), 64'd0);
        chk("ready_pulse", 64'(in_ready), 64'd0);
        tick();
        chk("cfgrst_end", 64'(config_reset), 64'd0);
        chk("running_end", 64'(running), 64'd1);
        chk("ready_run", 64'(in_ready), 64'd0);
        chk("strobe_run", 64'(write_config_data), 64'd0);
        chk("cnt_run", 64'(entries_written), 64'(m_cnt));
        chk("err_run", 64'(err_bad_entry), 64'(m_err));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n    = 1'b0;
        load_start = 1'b0;
        drive(mk(0, 1'b0, 0, 0, 0), 1'b0, 1'b0);
        #3;
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_strobe", 64'(write_config_data), 64'd0);
        chk("rst_cfgrst", 64'(config_reset), 64'd0);
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_err", 64'(err_bad_entry), 64'd0);
        chk("rst_cnt", 64'(entries_written), 64'd0);
        chk("rst_op", 64'(config_op), 64'd0);
        chk("rst_cd", 64'(config_const_data), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        drive(rnd(1'b0), 1'b1, 1'b1);
        tick();
        chk("idle_ready", 64'(in_ready), 64'd0);
        chk("idle_strobe", 64'(write_config_data), 64'd0);
        tick();
        chk("idle_strobe2", 64'(write_config_data), 64'd0);
        drive(rnd(1'b0), 1'b0, 1'b0);

        sess = {};
        sess.push_back(mk(0, 1'b0, 0, 1, 0));
        sess.push_back(mk(3, 1'b0, 1, 5, 32'h1234));
        sess.push_back(mk(15, 1'b0, 7, 8, 0));
        run_session(0, 1'b0, 1'b0);
        chk("a_cnt3", 64'(entries_written), 64'd3);

        sess = {};
        sess.push_back(mk(9, 1'b1, 2, 7, 32'hCAFE));
        run_session(0, 1'b0, 1'b1);
        chk("b_cnt1", 64'(entries_written), 64'd1);

        sess = {};
        sess.push_back(mk(20, 1'b0, 3, 2, 32'hBAD));
        sess.push_back(mk(1, 1'b0, 0, 4, 32'h55));
        run_session(0, 1'b0, 1'b1);
        chk("c_err", 64'(err_bad_entry), 64'd1);
        chk("c_cnt", 64'(entries_written), 64'd1);

        sess = {};
        for (int i = 0; i < 4; i++) sess.push_back(rnd(1'b0));
        run_session(2, 1'b1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            sess = {};
            for (int i = 0; i < 1 + $urandom_range(0, 7); i++) begin
                sess.push_back(rnd(1'b1));
            end
            run_session(-1, 1'b0, 1'b1);
        end

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        drive(mk(20, 1'b0, 1, 3, 7), 1'b1, 1'b0);
        tick();
        drive(mk(4, 1'b0, 2, 6, 32'h77), 1'b1, 1'b0);
        tick();
        chk("pre_rst_strobe", 64'(write_config_data), 64'h0010);
        chk("pre_rst_err", 64'(err_bad_entry), 64'd1);
        chk("pre_rst_cnt", 64'(entries_written), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_strobe", 64'(write_config_data), 64'd0);
        chk("arst_cfgrst", 64'(config_reset), 64'd0);
        chk("arst_running", 64'(running), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd0);
        chk("arst_err", 64'(err_bad_entry), 64'd0);
        chk("arst_cnt", 64'(entries_written), 64'd0);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("post_rst_ready", 64'(in_ready), 64'd0);
            chk("post_rst_strobe", 64'(write_config_data), 64'd0);
            chk("post_rst_cnt", 64'(entries_written), 64'd0);
        end
        drive(rnd(1'b0), 1'b0, 1'b0);

        sess = {};
        for (int i = 0; i < 3; i++) sess.push_back(rnd(1'b1));
        run_session(-1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
